// File: rtl/i2s_in_pkg.sv
// Shared types and defaults for the I2S input deserialiser.
// Macro I2S_IN_OVF_CNT_EN adds a saturating dropped-word counter to i2s_in_deser.
package i2s_in_pkg;

  localparam int DATA_SIZE_DEF   = 32;
  localparam int SAMPLE_BITS_DEF = 24;
  localparam int OVF_CNT_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HUNT  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
    if (v == {OVF_CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + OVF_CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/i2s_in_sync.sv
// Multi-stage synchronisers for the I2S lines plus a one-clock strobe on each
// synchronised sck rising edge; ws_s/sd_s are aligned with that strobe.
module i2s_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sck,
  input  logic ws,
  input  logic sd,
  output logic strobe,
  output logic ws_s,
  output logic sd_s
);

  logic [SYNC_STAGES-1:0] sck_q, sck_d;
  logic [SYNC_STAGES-1:0] ws_q, ws_d;
  logic [SYNC_STAGES-1:0] sd_q, sd_d;
  logic                   sck_prev_q, sck_prev_d;

  // Shift each raw line one stage deeper per clock.
  always_comb begin
    sck_d      = {sck_q[SYNC_STAGES-2:0], sck};
    ws_d       = {ws_q[SYNC_STAGES-2:0], ws};
    sd_d       = {sd_q[SYNC_STAGES-2:0], sd};
    sck_prev_d = sck_q[SYNC_STAGES-1];
  end

  // Synchroniser and edge-detect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q      <= '0;
      ws_q       <= '0;
      sd_q       <= '0;
      sck_prev_q <= 1'b0;
    end else begin
      sck_q      <= sck_d;
      ws_q       <= ws_d;
      sd_q       <= sd_d;
      sck_prev_q <= sck_prev_d;
    end
  end

  assign strobe = sck_q[SYNC_STAGES-1] & ~sck_prev_q;
  assign ws_s   = ws_q[SYNC_STAGES-1];
  assign sd_s   = sd_q[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_in_deser.sv
// I2S receiver front end: deserialises each channel MSB-first into a left-justified word
// and offers it to the FIFO over rts/rtr. Macro I2S_IN_OVF_CNT_EN adds the ovf_cnt port.
module i2s_in_deser
  import i2s_in_pkg::*;
#(
  parameter int DATA_SIZE   = DATA_SIZE_DEF,
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 i2s_sck,
  input  logic                 i2s_ws,
  input  logic                 i2s_sd,
  output logic [DATA_SIZE-1:0] fifo_inp_data,
  output logic                 fifo_inp_rts,
  input  logic                 fifo_inp_rtr,
  output logic                 out_chan,
  output logic                 ovf,
  input  logic                 ovf_clr
`ifdef I2S_IN_OVF_CNT_EN
  ,
  output logic [OVF_CNT_W-1:0] ovf_cnt
`endif
);

  localparam int CNT_W = $clog2(SAMPLE_BITS + 1);

  logic strobe_s, ws_s, sd_s, ws_edge_s, xfer_s, drop_s;
  logic [DATA_SIZE-1:0] word_s;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SAMPLE_BITS-1:0] shift_q, shift_d;
  logic                   chan_q, chan_d;
  logic                   ws_prev_q, ws_prev_d;
  logic                   ws_vld_q, ws_vld_d;
  logic                   done_q, done_d;
  logic [DATA_SIZE-1:0]   data_q, data_d;
  logic                   rts_q, rts_d;
  logic                   out_chan_q, out_chan_d;
  logic                   ovf_q, ovf_d;

  i2s_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sck    (i2s_sck),
    .ws     (i2s_ws),
    .sd     (i2s_sd),
    .strobe (strobe_s),
    .ws_s   (ws_s),
    .sd_s   (sd_s)
  );

  // ws_vld gates the first strobe after reset so a stale ws_prev never fakes an edge.
  assign ws_edge_s = strobe_s & ws_vld_q & (ws_s != ws_prev_q);

  // Channel framing state machine and shift register.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    chan_d    = chan_q;
    ws_prev_d = ws_prev_q;
    ws_vld_d  = ws_vld_q;
    done_d    = 1'b0;
    if (strobe_s) begin
      ws_prev_d = ws_s;
      ws_vld_d  = 1'b1;
    end else begin
      ws_prev_d = ws_prev_q;
      ws_vld_d  = ws_vld_q;
    end
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_HUNT;
        ST_HUNT, ST_SHIFT, ST_WAIT: begin
          if (ws_edge_s) begin
            // The sd bit on the edge strobe is the old channel's LSB; drop it.
            state_d = ST_SHIFT;
            cnt_d   = '0;
            shift_d = '0;
            chan_d  = ws_s;
          end else if (strobe_s && state_q == ST_SHIFT) begin
            shift_d = SAMPLE_BITS'({shift_q, sd_s});
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(SAMPLE_BITS - 1)) begin
              done_d  = 1'b1;
              state_d = ST_WAIT;
            end else begin
              state_d = ST_SHIFT;
            end
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Framing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      chan_q    <= 1'b0;
      ws_prev_q <= 1'b0;
      ws_vld_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      chan_q    <= chan_d;
      ws_prev_q <= ws_prev_d;
      ws_vld_q  <= ws_vld_d;
      done_q    <= done_d;
    end
  end

  // shift_q/chan_q stay stable for the clock after completion since strobes are >= 4 clks apart.
  always_comb begin
    word_s = '0;
    word_s[DATA_SIZE-1 -: SAMPLE_BITS] = shift_q;
    xfer_s     = rts_q & fifo_inp_rtr;
    drop_s     = 1'b0;
    data_d     = data_q;
    rts_d      = rts_q;
    out_chan_d = out_chan_q;
    if (done_q) begin
      if (!rts_q || xfer_s) begin
        data_d     = word_s;
        rts_d      = 1'b1;
        out_chan_d = chan_q;
      end else begin
        drop_s = 1'b1;
      end
    end else if (xfer_s) begin
      rts_d = 1'b0;
    end else begin
      rts_d = rts_q;
    end
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Output register toward the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      rts_q      <= 1'b0;
      out_chan_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      data_q     <= data_d;
      rts_q      <= rts_d;
      out_chan_q <= out_chan_d;
      ovf_q      <= ovf_d;
    end
  end

  assign fifo_inp_data = data_q;
  assign fifo_inp_rts  = rts_q;
  assign out_chan      = out_chan_q;
  assign ovf           = ovf_q;

`ifdef I2S_IN_OVF_CNT_EN
  logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  // Dropped-word counter; clear beats increment.
  always_comb begin
    if (ovf_clr) begin
      ovf_cnt_d = '0;
    end else if (drop_s) begin
      ovf_cnt_d = sat_inc(ovf_cnt_q);
    end else begin
      ovf_cnt_d = ovf_cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_in_deser.sv
// Scoreboard bench for i2s_in_deser: I2S slots are built as per-sck-cycle tables, the
// expected words follow from slot length and content, and a monitor checks every transfer.
module tb_i2s_in_deser;
  localparam int DS = 32;
  localparam int SB = 24;

  typedef struct packed {
    logic [DS-1:0] data;
    logic          chan;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, enable, sck, ws, sd, rtr, ovf_clr;
  logic [DS-1:0] data;
  logic rts, chan, ovf;
`ifdef I2S_IN_OVF_CNT_EN
  logic [7:0] ovf_cnt;
`endif

  exp_t exp_q[$];
  logic cyc_ws[$];
  logic cyc_sd[$];
  int   cyc_act[$];
  int   errors = 0;
  int   checks = 0;
  int   rts_rises = 0;
  logic rts_prev = 1'b0;
  bit   rand_rtr = 1'b0;
  logic [DS-1:0] t5_word;

  i2s_in_deser dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .i2s_sck       (sck),
    .i2s_ws        (ws),
    .i2s_sd        (sd),
    .fifo_inp_data (data),
    .fifo_inp_rts  (rts),
    .fifo_inp_rtr  (rtr),
    .out_chan      (chan),
    .ovf           (ovf),
    .ovf_clr       (ovf_clr)
`ifdef I2S_IN_OVF_CNT_EN
    ,
    .ovf_cnt       (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Left-justify the first SB transmitted bits of a 32-bit slot value.
  function automatic logic [DS-1:0] ref_word(input logic [31:0] v);
    logic [DS-1:0] t;
    t = DS'(v >> (32 - SB));
    return t << (DS - SB);
  endfunction

  // A slot of len sck cycles with ws=w; cycle 0 carries the previous channel's LSB,
  // cycles 1.. carry v MSB-first. Only slots with >= SB data bits produce a word.
  task automatic add_slot(input logic w, input int len, input logic [31:0] v,
                          input bit expect_out, input int act_at, input int act);
    for (int k = 0; k < len; k++) begin
      cyc_ws.push_back(w);
      cyc_sd.push_back((k == 0) ? 1'($urandom_range(0, 1)) : v[32-k]);
      cyc_act.push_back((k == act_at) ? act : 0);
    end
    if (expect_out && (len - 1 >= SB)) exp_q.push_back('{data: ref_word(v), chan: w});
  endtask

  task automatic preamble(input logic first_ws);
    add_slot(~first_ws, 3, 32'h0, 1'b0, -1, 0);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      if (rand_rtr) begin
        #1;
        rtr = ($urandom_range(0, 3) != 0);
      end
    end
  endtask

  task automatic sck_cycle(input logic w, input logic d, input int act);
    tick(1);
    #1;
    sck = 1'b0; ws = w; sd = d;
    tick(4);
    #1;
    sck = 1'b1;
    case (act)
      1: begin
        tick(1); #1; rst_n = 1'b0; #1;
        check("rst_data", data, 64'h0);
        check("rst_rts", rts, 64'h0);
        check("rst_chan", chan, 64'h0);
        check("rst_ovf", ovf, 64'h0);
        tick(3); #1; rst_n = 1'b1;
      end
      2: begin
        tick(3); #1; rtr = 1'b1;
        tick(1); #1;
        check("same_clk_rts", rts, 64'h1);
        check("same_clk_data", data, t5_word);
        check("same_clk_ovf", ovf, 64'h0);
        tick(2);
      end
      3: begin enable = 1'b0; rtr = 1'b1; tick(3); end
      4: begin enable = 1'b1; tick(3); end
      default: tick(3);
    endcase
  endtask

  task automatic run_stream();
    while (cyc_ws.size() > 0) sck_cycle(cyc_ws.pop_front(), cyc_sd.pop_front(), cyc_act.pop_front());
    tick(8);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      tick(1);
      n++;
    end
    check(name, exp_q.size(), 64'h0);
  endtask

  // Scoreboard monitor: every accepted transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (rts && !rts_prev) rts_rises++;
    rts_prev = rts;
    if (rst_n && rts && rtr) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h chan %0d expected no transfer", data, chan);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("xfer_data", data, e.data);
        check("xfer_chan", chan, e.chan);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    logic        w;
    rst_n = 1'b0; enable = 1'b0; sck = 1'b0; ws = 1'b0; sd = 1'b0; rtr = 1'b1; ovf_clr = 1'b0;
    #1;
    check("init_data", data, 64'h0);
    check("init_rts", rts, 64'h0);
    check("init_chan", chan, 64'h0);
    check("init_ovf", ovf, 64'h0);
`ifdef I2S_IN_OVF_CNT_EN
    check("init_ovf_cnt", ovf_cnt, 64'h0);
`endif
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1; enable = 1'b1;

    // Basic left/right words, one rts pulse each
    rts_rises = 0;
    preamble(1'b0);
    add_slot(1'b0, 32, {24'hA5A5A5, 8'($urandom)}, 1'b1, -1, 0);
    add_slot(1'b1, 32, {24'h5A5A5A, 8'($urandom)}, 1'b1, -1, 0);
    run_stream();
    drain("t2_drain");
    check("t2_rts_pulses", rts_rises, 64'h2);

    // Reset in the middle of a right-channel word
    preamble(1'b0);
    add_slot(1'b0, 32, $urandom, 1'b1, -1, 0);
    add_slot(1'b1, 32, $urandom, 1'b0, 10, 1);
    add_slot(1'b0, 32, $urandom, 1'b1, -1, 0);
    add_slot(1'b1, 32, $urandom, 1'b1, -1, 0);
    run_stream();
    drain("t1_drain");

    // Short frame discarded
    preamble(1'b0);
    add_slot(1'b0, 32, $urandom, 1'b1, -1, 0);
    add_slot(1'b1, 11, $urandom, 1'b1, -1, 0);
    add_slot(1'b0, 32, $urandom, 1'b1, -1, 0);
    add_slot(1'b1, 32, $urandom, 1'b1, -1, 0);
    run_stream();
    drain("t4_drain");

    // Backpressure across three words
    rtr = 1'b0;
    v = $urandom;
    preamble(1'b0);
    add_slot(1'b0, 32, v, 1'b1, -1, 0);
    add_slot(1'b1, 32, $urandom, 1'b0, -1, 0);
    add_slot(1'b0, 32, $urandom, 1'b0, -1, 0);
    run_stream();
    @(negedge clk);
    check("t3_ovf", ovf, 64'h1);
    check("t3_held_rts", rts, 64'h1);
    check("t3_held_data", data, ref_word(v));
`ifdef I2S_IN_OVF_CNT_EN
    check("t3_ovf_cnt", ovf_cnt, 64'h2);
`endif
    rtr = 1'b1;
    drain("t3_drain");
    @(posedge clk); #1; ovf_clr = 1'b1;
    @(posedge clk); #1; ovf_clr = 1'b0;
    check("t3_ovf_clr", ovf, 64'h0);
`ifdef I2S_IN_OVF_CNT_EN
    check("t3_ovf_cnt_clr", ovf_cnt, 64'h0);
`endif

    // Completion on the same clock as an accepted transfer
    rtr = 1'b0;
    v = $urandom;
    t5_word = ref_word(v);
    preamble(1'b0);
    add_slot(1'b0, 32, $urandom, 1'b1, -1, 0);
    add_slot(1'b1, 32, v, 1'b1, SB, 2);
    run_stream();
    drain("t5_drain");
    check("t5_ovf", ovf, 64'h0);

    // enable drop with a pending word
    rtr = 1'b0;
    preamble(1'b0);
    add_slot(1'b0, 32, $urandom, 1'b1, -1, 0);
    add_slot(1'b1, 32, $urandom, 1'b0, 10, 3);
    add_slot(1'b0, 32, $urandom, 1'b0, -1, 0);
    add_slot(1'b1, 32, $urandom, 1'b0, 5, 4);
    add_slot(1'b0, 32, $urandom, 1'b1, -1, 0);
    run_stream();
    drain("t6_drain");

    // Randomised slot lengths and data with random backpressure
    rand_rtr = 1'b1;
    for (int s = 0; s < 4; s++) begin
      w = 1'($urandom_range(0, 1));
      preamble(w);
      for (int j = 0; j < 6; j++) begin
        add_slot(w, $urandom_range(8, 33), $urandom, 1'b1, -1, 0);
        w = ~w;
      end
      run_stream();
    end
    rand_rtr = 1'b0;
    rtr = 1'b1;
    drain("rand_drain");
    check("final_ovf", ovf, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
